debounced_key_pio: RTL
======================

# debounced_key_pio

Parametrised Avalon-MM key/switch input port for the Qsys system: synchronises up to 16 asynchronous inputs, debounces each channel, and detects per-channel programmable edges into a sticky, write-1-to-clear capture register that raises a maskable interrupt. It replaces the fixed 4-bit falling-edge key port on the peripheral bus. Software reads the debounced level, the edge mode, the mask and the capture register.

## Interface
- `WIDTH`, 4: number of input channels, 1..16.
- `DEBOUNCE_CYCLES`, 50000: consecutive cycles of a changed synchronised level required before it is accepted, at least 1.
- `IDLE_LEVEL`, {WIDTH{1'b1}}: reset value of the synchroniser and debounced level; keys are active-low.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `address` in 2: register select.
- `chipselect` in 1: slave select.
- `write_n` in 1: active-low write strobe.
- `writedata` in 32: write data.
- `in_port` in WIDTH: asynchronous inputs.
- `readdata` out 32: registered read data; reset 0.
- `irq` out 1: interrupt; reset 0.

## Operation
- Register map; all unused bits read 0 and are ignored on write.
  - Address 0, DATA, read-only: debounced level `q[WIDTH-1:0]`. Writes are ignored.
  - Address 1, MODE, read/write: 2 bits per channel at `[2i+1:2i]`.
    - 00: disabled. 01: rising. 10: falling. 11: both.
    - Reset value: 10 for every channel.
  - Address 2, MASK, read/write: `[WIDTH-1:0]`; reset 0.
  - Address 3, CAPTURE: read returns the sticky edge bits. Writing 1 to a bit clears that bit; writing 0 leaves it unchanged.
- A write occurs when `chipselect` is 1 and `write_n` is 0.
- Synchroniser: two flops per channel, `s1` then `s2`, both reset to `IDLE_LEVEL`.
- Debounce, per channel, with counter `cnt` of width clog2(DEBOUNCE_CYCLES):
  - If `s2 == q`: `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `q <= s2` and `cnt <= 0`.
  - Else: `cnt <= cnt+1`.
  - A glitch shorter than `DEBOUNCE_CYCLES` cycles never reaches `q`.
- Edge event, per channel, asserted in the cycle `q` is about to change:
  - Rising event: `q` goes 0→1 and `MODE[2i]` is 1.
  - Falling event: `q` goes 1→0 and `MODE[2i+1]` is 1.
- Capture bit: set on an event. Cleared by a write-1 to CAPTURE when no event occurs in the same cycle.
  - Event and write-1-clear in the same cycle: the bit is set; the set wins, so no edge is lost.
- `irq = |(CAPTURE & MASK)`, combinational from registers.
  - Changing MASK affects `irq` in the cycle after the write.
- Reset:
  - `q` and the synchroniser load `IDLE_LEVEL`; `cnt`, CAPTURE, MASK and `readdata` go to 0; MODE goes to all-10.
  - Reset in the middle of a debounce discards the partial count; no event is generated by reset.

## Timing
- Read latency is 1 cycle: `readdata` at edge n+1 reflects the `address` presented at edge n. It is updated every cycle, independent of `chipselect`.
- Write latency: a register written at edge n shows its new value at edge n+1.
- Input path:
  - `in_port` stable from before edge 0: `s2` changes at edge 2.
  - `q` and CAPTURE update at edge 2+DEBOUNCE_CYCLES.
  - `irq` rises in the same cycle as CAPTURE if the channel is unmasked.
- A read of CAPTURE in the cycle an event sets it returns the pre-event value.

## Configuration
- `DEBOUNCE_KEY_PIO_DEBOUNCE_EN`
  - Defined: debounce counters are built as described.
  - Undefined: no counters. `q <= s2` every cycle, which is identical to `DEBOUNCE_CYCLES = 1`. `q` and events then update at edge 3 after an input change.
  - Register map, `irq` and read timing are unchanged in both builds.

## Test plan
- Reset check, with `WIDTH=4`, `DEBOUNCE_CYCLES=4`, `in_port=4'hF` held: DATA reads 0xF, MODE reads 0xAA, MASK reads 0, CAPTURE reads 0 and `irq` is 0 after reset.
- Debounced falling edge:
  - Stimulus: write MASK=0x1; drive `in_port[0]` low at edge 0.
  - Required: `q[0]` and CAPTURE[0] change at edge 6; `irq`=1 from edge 6.
  - Then write CAPTURE=0x1: `irq`=0 on the next cycle.
- Glitch rejection: pulse `in_port[1]` low for 3 cycles with `DEBOUNCE_CYCLES=4`. DATA stays 0xF and CAPTURE stays 0.
- Modes:
  - MODE=0x01 (ch0 rising): falling edges on ch0 are not captured; a rising edge sets CAPTURE[0].
  - MODE=0x03 (ch0 both): a low pulse longer than `DEBOUNCE_CYCLES`, cleared between edges, sets CAPTURE[0] twice.
  - MODE=0x00 (ch0 disabled): no capture on either edge.
- Set/clear collision: issue a write CAPTURE=0x4 in the exact cycle a ch2 event occurs. CAPTURE[2] remains 1 afterwards.
- Build without the macro: an input change is reflected in DATA and CAPTURE at edge 3; a 2-cycle glitch is captured.

Source files
------------

// File: rtl/debounced_key_pio.sv
`default_nettype none
// ============================================================================
// Module      : debounced_key_pio
// Description : Avalon-MM key/switch input port. Two-flop synchronises up to
//               16 asynchronous inputs, debounces each channel, and captures
//               programmable per-channel edges into a sticky write-1-to-clear
//               register that drives a maskable interrupt.
//               Build option DEBOUNCE_KEY_PIO_DEBOUNCE_EN: when defined, the
//               per-channel debounce counters are built; when undefined the
//               debounced level simply follows the synchroniser output.
// Revision    : 1.0 - initial release
// ============================================================================
module debounced_key_pio #(
    parameter int               WIDTH           = 4,
    parameter int               DEBOUNCE_CYCLES = 50000,
    parameter logic [WIDTH-1:0] IDLE_LEVEL      = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [2*WIDTH-1:0] C_MODE_RESET = {WIDTH{2'b10}};

    logic [WIDTH-1:0]   s1_q, s2_q;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [2*WIDTH-1:0] mode_q, mode_d;
    logic [WIDTH-1:0]   mask_q, mask_d;
    logic [WIDTH-1:0]   cap_q, cap_d;
    logic [31:0]        readdata_q, readdata_d;
    logic [WIDTH-1:0]   w_event;
    logic [WIDTH-1:0]   w_clr;
    logic               w_wr;

    // Upper writedata bits are ignored; the build without counters has no
    // use for the debounce length.
    logic w_unused;
    assign w_unused = ^{writedata, (DEBOUNCE_CYCLES > 0)};

    assign w_wr = chipselect & ~write_n;

`ifdef DEBOUNCE_KEY_PIO_DEBOUNCE_EN
    localparam int               C_CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(DEBOUNCE_CYCLES - 1);

    for (genvar i = 0; i < WIDTH; i++) begin : g_deb
        logic [C_CNT_W-1:0] cnt_q, cnt_d;
        logic               q_nxt;

        // Accept a changed level only after it has persisted for the full count
        always_comb begin
            cnt_d = cnt_q;
            q_nxt = q_q[i];
            if (s2_q[i] == q_q[i]) begin
                cnt_d = '0;
            end else if (cnt_q == C_CNT_LAST) begin
                q_nxt = s2_q[i];
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + C_CNT_W'(1);
            end
        end

        // Per-channel stability counter
        always_ff @(posedge clk) begin
            if (reset) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign q_d[i] = q_nxt;
    end : g_deb
`else
    assign q_d = s2_q;
`endif

    // Edge events are judged on the level transition about to be committed;
    // a capture set in the same cycle as a clear wins so no edge is lost.
    always_comb begin
        w_event = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_event[i] = (~q_q[i] &  q_d[i] & mode_q[2*i]) |
                         ( q_q[i] & ~q_d[i] & mode_q[2*i+1]);
        end
        w_clr  = (w_wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
        cap_d  = (cap_q & ~w_clr) | w_event;
        mode_d = (w_wr && address == 2'd1) ? writedata[2*WIDTH-1:0] : mode_q;
        mask_d = (w_wr && address == 2'd2) ? writedata[WIDTH-1:0]   : mask_q;
    end

    // Read mux, registered every cycle regardless of chipselect
    always_comb begin
        readdata_d = '0;
        case (address)
            2'd0:    readdata_d = 32'(q_q);
            2'd1:    readdata_d = 32'(mode_q);
            2'd2:    readdata_d = 32'(mask_q);
            default: readdata_d = 32'(cap_q);
        endcase
    end

    // Synchroniser, debounced level and register state
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q       <= IDLE_LEVEL;
            s2_q       <= IDLE_LEVEL;
            q_q        <= IDLE_LEVEL;
            mode_q     <= C_MODE_RESET;
            mask_q     <= '0;
            cap_q      <= '0;
            readdata_q <= '0;
        end else begin
            s1_q       <= in_port;
            s2_q       <= s1_q;
            q_q        <= q_d;
            mode_q     <= mode_d;
            mask_q     <= mask_d;
            cap_q      <= cap_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(cap_q & mask_q);

endmodule : debounced_key_pio
`default_nettype wire
